// File: rtl/lvdsdata_to_native_ex.sv
// Registered LVDS-word to native RGB/HS/VS/DE decoder with DE check and active-size measurement.
// Optional build macro LVDS_NATIVE_POL_AUTO_EN adds a sync-polarity normaliser in stage1.
module lvdsdata_to_native_ex #(
    parameter int C_PORT_NUM = 4,
    parameter int C_BPC      = 8,
    parameter int C_CNT_W    = 16
) (
    input  logic                      CLK_I,
    input  logic                      RSTN_I,
    input  logic [28*C_PORT_NUM-1:0]  LVDS_DATA_I,
    input  logic                      MAP_MODE_I,
    input  logic                      ERR_CLR_I,
    output logic [8*C_PORT_NUM-1:0]   R_O,
    output logic [8*C_PORT_NUM-1:0]   G_O,
    output logic [8*C_PORT_NUM-1:0]   B_O,
    output logic                      HS_O,
    output logic                      VS_O,
    output logic                      DE_O,
    output logic [C_CNT_W-1:0]        H_ACTIVE_O,
    output logic [C_CNT_W-1:0]        V_ACTIVE_O,
    output logic                      FRAME_DONE_O,
    output logic                      DE_ERR_O
);

    localparam logic [C_CNT_W:0] PORT_INC = (C_CNT_W+1)'(C_PORT_NUM);

    function automatic logic [7:0] map_field(input logic [7:0] v, input logic jeida);
        logic [7:0] res;
        if (C_BPC == 6)
            res = {v[5:0], v[5:4]};
        else if (jeida)
            res = {v[5:0], v[7:6]};
        else
            res = v;
        return res;
    endfunction

    function automatic logic [23:0] decode(input logic [27:0] w, input logic jeida);
        logic [7:0] vr;
        logic [7:0] vg;
        logic [7:0] vb;
        vr = {w[23], w[27], w[4],  w[8],  w[12], w[16], w[20], w[24]};
        vg = {w[15], w[19], w[9],  w[13], w[17], w[21], w[25], w[0]};
        vb = {w[7],  w[11], w[14], w[18], w[22], w[26], w[1],  w[5]};
        return {map_field(vr, jeida), map_field(vg, jeida), map_field(vb, jeida)};
    endfunction

    logic [8*C_PORT_NUM-1:0] r_d, g_d, b_d;
    logic [8*C_PORT_NUM-1:0] r_s1, g_s1, b_s1;
    logic                    mis_d, mis_s1;
    logic                    hs_in, vs_in, de_in;
    logic                    hs_norm, vs_norm;
    logic                    hs_s1, vs_s1, de_s1;

    logic [C_CNT_W-1:0]      h_cnt, h_last, v_cnt;
    logic [C_CNT_W-1:0]      h_inc, v_inc;
    logic [C_CNT_W:0]        h_sum;
    logic                    armed;
    logic                    de_fall, vs_rise;

    assign hs_in = LVDS_DATA_I[10];
    assign vs_in = LVDS_DATA_I[6];
    assign de_in = LVDS_DATA_I[2];

    always_comb begin
        r_d   = '0;
        g_d   = '0;
        b_d   = '0;
        mis_d = 1'b0;
        for (int p = 0; p < C_PORT_NUM; p++) begin
            {r_d[8*p +: 8], g_d[8*p +: 8], b_d[8*p +: 8]} = decode(LVDS_DATA_I[28*p +: 28], MAP_MODE_I);
            if (LVDS_DATA_I[28*p+2] != de_in)
                mis_d = 1'b1;
        end
    end

`ifdef LVDS_NATIVE_POL_AUTO_EN
    logic hs_idle, vs_idle;
    logic de_rise_in;

    // On the DE rising edge the new idle level is used straight away so that cycle is already normalised.
    assign de_rise_in = de_in & ~de_s1;
    assign hs_norm    = hs_in ^ (de_rise_in ? hs_in : hs_idle);
    assign vs_norm    = vs_in ^ (de_rise_in ? vs_in : vs_idle);

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            hs_idle <= 1'b0;
            vs_idle <= 1'b0;
        end else if (de_rise_in) begin
            hs_idle <= hs_in;
            vs_idle <= vs_in;
        end
    end
`else
    assign hs_norm = hs_in;
    assign vs_norm = vs_in;
`endif

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            r_s1   <= '0;
            g_s1   <= '0;
            b_s1   <= '0;
            hs_s1  <= 1'b0;
            vs_s1  <= 1'b0;
            de_s1  <= 1'b0;
            mis_s1 <= 1'b0;
        end else begin
            r_s1   <= r_d;
            g_s1   <= g_d;
            b_s1   <= b_d;
            hs_s1  <= hs_norm;
            vs_s1  <= vs_norm;
            de_s1  <= de_in;
            mis_s1 <= mis_d;
        end
    end

    // A clear arriving together with a new mismatch must not drop the flag.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            R_O      <= '0;
            G_O      <= '0;
            B_O      <= '0;
            HS_O     <= 1'b0;
            VS_O     <= 1'b0;
            DE_O     <= 1'b0;
            DE_ERR_O <= 1'b0;
        end else begin
            R_O      <= r_s1;
            G_O      <= g_s1;
            B_O      <= b_s1;
            HS_O     <= hs_s1;
            VS_O     <= vs_s1;
            DE_O     <= de_s1;
            DE_ERR_O <= (DE_ERR_O & ~ERR_CLR_I) | mis_s1;
        end
    end

    // Stage2 DE/VS registers double as the previous stage1 values for edge detection.
    assign de_fall = DE_O & ~de_s1;
    assign vs_rise = vs_s1 & ~VS_O;
    assign h_sum   = {1'b0, h_cnt} + PORT_INC;
    assign h_inc   = h_sum[C_CNT_W] ? {C_CNT_W{1'b1}} : h_sum[C_CNT_W-1:0];
    assign v_inc   = (&v_cnt) ? v_cnt : v_cnt + C_CNT_W'(1);

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            h_cnt        <= '0;
            h_last       <= '0;
            v_cnt        <= '0;
            armed        <= 1'b0;
            H_ACTIVE_O   <= '0;
            V_ACTIVE_O   <= '0;
            FRAME_DONE_O <= 1'b0;
        end else begin
            FRAME_DONE_O <= 1'b0;
            if (de_s1)
                h_cnt <= h_inc;
            if (de_fall) begin
                h_last <= h_cnt;
                h_cnt  <= '0;
                v_cnt  <= v_inc;
            end
            if (vs_rise) begin
                if (armed) begin
                    H_ACTIVE_O   <= de_fall ? h_cnt : h_last;
                    V_ACTIVE_O   <= de_fall ? v_inc : v_cnt;
                    FRAME_DONE_O <= 1'b1;
                end
                v_cnt <= '0;
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lvdsdata_to_native_ex.sv
// Randomized self-checking bench for lvdsdata_to_native_ex against a bit-table reference model.
module tb_lvdsdata_to_native_ex;

    localparam int P   = 4;
    localparam int BPC = 8;
    localparam int CW  = 16;
    localparam int VW  = 24*P + 3;
`ifdef LVDS_NATIVE_POL_AUTO_EN
    localparam bit ACT = 1'b0;
`else
    localparam bit ACT = 1'b1;
`endif
    localparam bit IDL = ~ACT;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [28*P-1:0]   data;
    logic              map_mode;
    logic              err_clr;
    logic [8*P-1:0]    r_o, g_o, b_o;
    logic              hs_o, vs_o, de_o;
    logic [CW-1:0]     h_act, v_act;
    logic              frame_done, de_err;
    logic [VW-1:0]     out_vec;

    int total = 0;
    int bad   = 0;

    int idx[3][8] = '{'{24, 20, 16, 12, 8, 4, 27, 23},
                      '{0, 25, 21, 17, 13, 9, 19, 15},
                      '{5, 1, 26, 22, 18, 14, 11, 7}};

    logic [VW-1:0] exp_prev;
    bit            prev_valid = 0;
    bit            mis_prev   = 0;
    bit            err_exp    = 0;
    bit            m_de_prev  = 0;
    bit            m_hs_idle  = 0;
    bit            m_vs_idle  = 0;
    int            pulses     = 0;

    lvdsdata_to_native_ex #(.C_PORT_NUM(P), .C_BPC(BPC), .C_CNT_W(CW)) dut (
        .CLK_I(clk), .RSTN_I(rst_n), .LVDS_DATA_I(data), .MAP_MODE_I(map_mode),
        .ERR_CLR_I(err_clr), .R_O(r_o), .G_O(g_o), .B_O(b_o), .HS_O(hs_o), .VS_O(vs_o),
        .DE_O(de_o), .H_ACTIVE_O(h_act), .V_ACTIVE_O(v_act), .FRAME_DONE_O(frame_done),
        .DE_ERR_O(de_err)
    );

    always #5 clk = ~clk;

    assign out_vec = {r_o, g_o, b_o, hs_o, vs_o, de_o};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output bit i of a colour takes field bit src: VESA identity, JEIDA rotated by two, 6bpc repeats bits 5:4 low.
    function automatic logic [23:0] ref_pix(input logic [27:0] w, input bit jeida);
        logic [23:0] res;
        int src;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (BPC == 6)
                    src = (i < 2) ? i + 4 : i - 2;
                else if (jeida)
                    src = (i + 6) % 8;
                else
                    src = i;
                res[8*(2-c) + i] = w[idx[c][src]];
            end
        end
        return res;
    endfunction

    task automatic tick();
        logic [8*P-1:0] er, eg, eb;
        logic [23:0]    pix;
        bit             de0, hs0, vs0, mis;
        de0 = data[2];
        hs0 = data[10];
        vs0 = data[6];
        mis = 0;
        for (int p = 0; p < P; p++) begin
            pix = ref_pix(data[28*p +: 28], map_mode);
            er[8*p +: 8] = pix[23:16];
            eg[8*p +: 8] = pix[15:8];
            eb[8*p +: 8] = pix[7:0];
            if (data[28*p+2] != de0)
                mis = 1;
        end
`ifdef LVDS_NATIVE_POL_AUTO_EN
        if (de0 && !m_de_prev) begin
            m_hs_idle = hs0;
            m_vs_idle = vs0;
        end
        hs0 = hs0 ^ m_hs_idle;
        vs0 = vs0 ^ m_vs_idle;
`endif
        m_de_prev = de0;
        err_exp = (err_exp & !err_clr) | mis_prev;
        @(posedge clk);
        #1;
        if (prev_valid)
            check("pixel", out_vec, exp_prev);
        check("de_err", de_err, err_exp);
        if (frame_done)
            pulses++;
        exp_prev   = {er, eg, eb, hs0, vs0, de0};
        prev_valid = 1;
        mis_prev   = mis;
    endtask

    task automatic drive(input bit de, input bit hs, input bit vs, input int bad_port);
        logic [27:0] w;
        for (int p = 0; p < P; p++) begin
            w     = 28'($urandom);
            w[2]  = (p == bad_port) ? ~de : de;
            w[6]  = vs;
            w[10] = hs;
            data[28*p +: 28] = w;
        end
        map_mode = 1'($urandom_range(0, 1));
        tick();
    endtask

    task automatic vs_pulse();
        repeat (3) drive(0, IDL, ACT, -1);
        repeat (4) drive(0, IDL, IDL, -1);
    endtask

    // merge_end makes the last DE fall coincide with the next VS rise.
    task automatic lines(input int n, input int len, input bit merge_end);
        for (int l = 0; l < n; l++) begin
            repeat (2) drive(0, ACT, IDL, -1);
            repeat (3) drive(0, IDL, IDL, -1);
            repeat (len) drive(1, IDL, IDL, -1);
            if (!(merge_end && l == n - 1))
                repeat (2) drive(0, IDL, IDL, -1);
        end
    endtask

    task automatic model_reset();
        prev_valid = 0;
        mis_prev   = 0;
        err_exp    = 0;
        m_de_prev  = 0;
        m_hs_idle  = 0;
        m_vs_idle  = 0;
        pulses     = 0;
    endtask

    initial begin
        int nl, ll;
        rst_n    = 1'b0;
        data     = '0;
        map_mode = 1'b0;
        err_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pix", out_vec, '0);
        check("reset_size", {h_act, v_act, frame_done, de_err}, '0);
        rst_n = 1'b1;
        model_reset();
        repeat (2) tick();

        // Single bit 24 on port 0 appears as R bit 0 exactly two clocks later.
        data     = '0;
        data[24] = 1'b1;
        tick();
        check("vesa_lat1", r_o, '0);
        data = '0;
        tick();
        check("vesa_r", r_o, 32'h1);
        check("vesa_rest", {g_o, b_o, hs_o, vs_o, de_o}, '0);
        map_mode = 1'b1;
        data[24] = 1'b1;
        tick();
        data = '0;
        tick();
        check("jeida_r", r_o[7:0], 8'h04);

        // Nominal frame: first VS arms only, second reports 480*4 by 10.
        vs_pulse();
`ifndef LVDS_NATIVE_POL_AUTO_EN
        check("no_first_pulse", pulses, 0);
`endif
        lines(10, 480, 0);
        vs_pulse();
        check("h_active", h_act, 16'd1920);
        check("v_active", v_act, 16'd10);
`ifndef LVDS_NATIVE_POL_AUTO_EN
        check("one_pulse", pulses, 1);
`endif

        // Random-size frame whose last DE fall meets the VS rise.
        nl = $urandom_range(2, 7);
        ll = $urandom_range(3, 40);
        lines(nl, ll, 1);
        vs_pulse();
        check("h_rand", h_act, 16'(ll * P));
        check("v_rand", v_act, 16'(nl));
`ifndef LVDS_NATIVE_POL_AUTO_EN
        check("two_pulses", pulses, 2);
`endif

        // DE cross-port mismatch, sticky flag, clear, then clear colliding with a new error.
        drive(1, IDL, IDL, 2);
        repeat (3) drive(1, IDL, IDL, -1);
        check("err_set", de_err, 1'b1);
        err_clr = 1'b1;
        drive(0, IDL, IDL, -1);
        err_clr = 1'b0;
        drive(0, IDL, IDL, -1);
        check("err_clr", de_err, 1'b0);
        drive(1, IDL, IDL, 1);
        drive(1, IDL, IDL, -1);
        drive(1, IDL, IDL, 3);
        err_clr = 1'b1;
        drive(1, IDL, IDL, -1);
        err_clr = 1'b0;
        check("err_clr_collide", de_err, 1'b1);

        // Asynchronous reset in the middle of a line.
        repeat (5) drive(1, IDL, IDL, -1);
        rst_n = 1'b0;
        #1;
        check("midrst_pix", out_vec, '0);
        check("midrst_misc", {h_act, v_act, frame_done, de_err}, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) drive(0, IDL, IDL, -1);
        vs_pulse();
`ifndef LVDS_NATIVE_POL_AUTO_EN
        check("rst_no_pulse", pulses, 0);
`endif
        lines(3, 7, 0);
        vs_pulse();
`ifndef LVDS_NATIVE_POL_AUTO_EN
        check("rst_pulse", pulses, 1);
`endif
        check("rst_h", h_act, 16'(7 * P));
        check("rst_v", v_act, 16'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
